// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU op codes, main-control
// ALUOp encodings, R-type funct values and the issue FSM state type.
package alu_pkg;

  // 4-bit ALU operation codes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // Main-control ALUOp encodings (11 is reserved and treated as illegal)
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Issue FSM: accept, let the ALU settle for one cycle, then hold the response
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of main-control ALUOp + funct into the 4-bit ALU op code.
// Anything that is not a recognised operation falls back to ADD and raises illegal.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] op,
  output logic       illegal
);

  // Map ALUOp/funct to an op code; default is ADD so an illegal op still yields a defined ALU setting
  always_comb begin
    op      = OP_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_MEM: op = OP_ADD;
      ALUOP_BR:  op = OP_SUB;
      ALUOP_R: begin
        case (funct)
          FUNCT_ADD: op = OP_ADD;
          FUNCT_SUB: op = OP_SUB;
          FUNCT_AND: op = OP_AND;
          FUNCT_OR:  op = OP_OR;
          FUNCT_NOR: op = OP_NOR;
          FUNCT_SLT: op = OP_SLT;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the datapath ALU: takes one request over
// valid/ready, drives the ALU from registers, captures Result/Zero after one
// execute cycle and returns them over a valid/ready response channel.
// Optional feature macro: ALU_ILLEGAL_TRAP_EN -- when defined, illegal decodes
// return rsp_err=1 with a zeroed result instead of the real ADD result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_aluop,
  input  logic [5:0]        req_funct,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  op_count
);

`ifdef ALU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t            state_reg, state_next;
  logic [3:0]        dec_op;
  logic              dec_illegal;
  logic              illegal_reg;
  logic [DATA_W-1:0] alu_in1_reg, alu_in2_reg, rsp_result_reg;
  logic [OP_W-1:0]   alu_op_reg;
  logic              rsp_zero_reg, rsp_err_reg;
  logic [CNT_W-1:0]  op_count_reg;

  alu_op_decode u_decode (
    .aluop   (req_aluop),
    .funct   (req_funct),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  // FSM state register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state: EXEC always lasts exactly one cycle, RESP waits for the consumer
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_valid) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    req_ready = (state_reg == ST_IDLE);
    rsp_valid = (state_reg == ST_RESP);
  end

  // Datapath: latch request on accept, capture ALU output at end of EXEC, count completed responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1_reg    <= '0;
      alu_in2_reg    <= '0;
      alu_op_reg     <= '0;
      illegal_reg    <= 1'b0;
      rsp_result_reg <= '0;
      rsp_zero_reg   <= 1'b0;
      rsp_err_reg    <= 1'b0;
      op_count_reg   <= '0;
    end else begin
      if (state_reg == ST_IDLE && req_valid) begin
        alu_in1_reg <= req_a;
        alu_in2_reg <= req_b;
        alu_op_reg  <= OP_W'(dec_op);
        illegal_reg <= dec_illegal;
      end
      if (state_reg == ST_EXEC) begin
        if (TRAP_EN && illegal_reg) begin
          rsp_result_reg <= '0;
          rsp_zero_reg   <= 1'b0;
          rsp_err_reg    <= 1'b1;
        end else begin
          rsp_result_reg <= alu_result;
          rsp_zero_reg   <= alu_zero;
          rsp_err_reg    <= 1'b0;
        end
      end
      if (state_reg == ST_RESP && rsp_ready) begin
        op_count_reg <= op_count_reg + 1'b1;
      end
    end
  end

  assign alu_in1    = alu_in1_reg;
  assign alu_in2    = alu_in2_reg;
  assign alu_op     = alu_op_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign rsp_err    = rsp_err_reg;
  assign op_count   = op_count_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, randomized ops
// against a behavioural model, stall/hold and reset-mid-EXEC sequences.
// The counter is narrowed to 8 bits so its wrap is reached in a short run.
module tb_alu_issue_ctrl;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_aluop = '0;
  logic [5:0]        req_funct = '0;
  logic [DATA_W-1:0] req_a = '0, req_b = '0;
  logic [DATA_W-1:0] alu_in1, alu_in2, alu_result;
  logic [OP_W-1:0]   alu_op;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero, rsp_err;
  logic [CNT_W-1:0]  op_count;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  // Stand-in for the datapath ALU (combinational)
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_in1 & alu_in2;
      4'b0001: alu_result = alu_in1 | alu_in2;
      4'b0010: alu_result = alu_in1 + alu_in2;
      4'b0110: alu_result = alu_in1 - alu_in2;
      4'b0111: alu_result = ($signed(alu_in1) < $signed(alu_in2)) ? 16'd1 : 16'd0;
      4'b1100: alu_result = ~(alu_in1 | alu_in2);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [15:0] a, b;
    logic [3:0]  exp_op;
    logic [15:0] exp_res;
    logic        exp_zero;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: what the operation means, not how the block computes it
  task automatic ref_model(input logic [1:0] aluop, input logic [5:0] funct,
                           input logic [15:0] a, input logic [15:0] b,
                           output logic [3:0] op, output logic [15:0] res,
                           output logic zero, output logic err);
    logic ill;
    int sa, sb;
    sa = $signed(a); sb = $signed(b);
    ill = 1'b0;
    if (aluop == 2'd0)      begin op = 4'b0010; res = a + b; end
    else if (aluop == 2'd1) begin op = 4'b0110; res = a - b; end
    else if (aluop == 2'd3) begin op = 4'b0010; res = a + b; ill = 1'b1; end
    else if (funct == 6'd32) begin op = 4'b0010; res = a + b; end
    else if (funct == 6'd34) begin op = 4'b0110; res = a - b; end
    else if (funct == 6'd36) begin op = 4'b0000; res = a & b; end
    else if (funct == 6'd37) begin op = 4'b0001; res = a | b; end
    else if (funct == 6'd39) begin op = 4'b1100; res = ~(a | b); end
    else if (funct == 6'd42) begin op = 4'b0111; res = (sa < sb) ? 16'd1 : 16'd0; end
    else begin op = 4'b0010; res = a + b; ill = 1'b1; end
    err = 1'b0;
    if (ill && TRAP) begin res = 16'd0; err = 1'b1; end
    zero = (res == 16'd0) && !(ill && TRAP);
  endtask

  // One complete transaction with optional response stall; when hold is set the
  // requester keeps req_valid high (with a different operand) during the stall
  task automatic do_op(input logic [1:0] aluop, input logic [5:0] funct,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] e_op, input logic [15:0] e_res,
                       input logic e_zero, input logic e_err,
                       input int stall, input bit hold);
    int waited;
    @(negedge clk);
    req_aluop = aluop; req_funct = funct; req_a = a; req_b = b; req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'(waited), 32'd0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    else req_a = ~a;
    @(negedge clk);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_req_ready", 32'(req_ready), 32'd0);
    chk("exec_alu_op", 32'(alu_op), 32'(e_op));
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    $display("op aluop=%b funct=%b a=%h b=%h -> res=%h zero=%0d err=%0d cnt=%0d",
             aluop, funct, a, b, rsp_result, rsp_zero, rsp_err, op_count);
    chk("rsp_result", 32'(rsp_result), 32'(e_res));
    chk("rsp_zero", 32'(rsp_zero), 32'(e_zero));
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_hold", {rsp_valid, req_ready, rsp_result, alu_in1[13:0]},
          {1'b1, 1'b0, e_res, a[13:0]});
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CNT_W);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("op_count", 32'(op_count), 32'(exp_count));
  endtask

  vec_t vecs[11];

  initial begin
    logic [3:0]  m_op;
    logic [15:0] m_res, ra, rb;
    logic        m_zero, m_err;
    logic [1:0]  raluop;
    logic [5:0]  rfunct;
    logic [5:0]  legal_f[6];
    legal_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};

    vecs[0]  = '{2'b10, 6'b100000, 16'h0003, 16'h0004, 4'b0010, 16'h0007, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 6'b000000, 16'h1234, 16'h1234, 4'b0110, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{2'b10, 6'b100010, 16'h0005, 16'h0007, 4'b0110, 16'hFFFE, 1'b0, 1'b0};
    vecs[3]  = '{2'b10, 6'b100100, 16'hF0F0, 16'hFF00, 4'b0000, 16'hF000, 1'b0, 1'b0};
    vecs[4]  = '{2'b10, 6'b100101, 16'hF0F0, 16'h0F00, 4'b0001, 16'hFFF0, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 6'b100111, 16'hF0F0, 16'h0F00, 4'b1100, 16'h000F, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 6'b101010, 16'hFFFF, 16'h0001, 4'b0111, 16'h0001, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 6'b101010, 16'h0001, 16'hFFFF, 4'b0111, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{2'b00, 6'b010101, 16'h0010, 16'h0020, 4'b0010, 16'h0030, 1'b0, 1'b0};
`ifdef ALU_ILLEGAL_TRAP_EN
    vecs[9]  = '{2'b10, 6'b111111, 16'h0001, 16'h0002, 4'b0010, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{2'b11, 6'b100000, 16'h0001, 16'h0002, 4'b0010, 16'h0000, 1'b0, 1'b1};
`else
    vecs[9]  = '{2'b10, 6'b111111, 16'h0001, 16'h0002, 4'b0010, 16'h0003, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 6'b100000, 16'h0001, 16'h0002, 4'b0010, 16'h0003, 1'b0, 1'b0};
`endif

    // Reset state
    #12;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_outputs", {rsp_valid, rsp_zero, rsp_err, op_count, alu_op, alu_in1, rsp_result}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 11; i++)
      do_op(vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].exp_op,
            vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_err, 0, 1'b0);

    // Long stall with the requester waiting: response stable, nothing new accepted
    do_op(2'b10, 6'b100000, 16'h0003, 16'h0004, 4'b0010, 16'h0007, 1'b0, 1'b0, 5, 1'b1);

    // Randomized ops; enough of them to carry the counter through its wrap
    for (int n = 0; n < 300; n++) begin
      raluop = 2'($urandom_range(0, 3));
      rfunct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 5)];
      ra = 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? ra : 16'($urandom);
      ref_model(raluop, rfunct, ra, rb, m_op, m_res, m_zero, m_err);
      do_op(raluop, rfunct, ra, rb, m_op, m_res, m_zero, m_err,
            $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Reset asserted during EXEC: immediate abort, counter cleared
    @(negedge clk);
    req_aluop = 2'b00; req_a = 16'h0101; req_b = 16'h0202; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_exec_req_ready", 32'(req_ready), 32'd1);
    chk("rst_exec_op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    chk("rst_no_response", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    exp_count = 0;
    do_op(2'b01, 6'b000000, 16'h0009, 16'h0004, 4'b0110, 16'h0005, 1'b0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
